serial_sub: RTL and testbench
=============================

// Module: serial_sub
// PURPOSE
//   Bit-serial subtractor: computes D = A - B - Bin, one bit per clock, LSB first.
//   It is the inverse-direction companion to fa4, the 4-bit combinational ripple
//   adder, and is sized for the same 4-bit datapath by default.
//   It trades area for latency and uses one full-subtractor cell plus a borrow flop.
//   A start/busy/done handshake exposes it to a controlling FSM or a testbench.
// PARAMETERS
//   WIDTH   4   operand and result width in bits (must be >= 2)
// PORTS
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous reset, active-high
//   start   in   1      request; sampled only when not busy
//   A       in   WIDTH  minuend; captured on the accepted start edge
//   B       in   WIDTH  subtrahend; captured on the accepted start edge
//   Bin     in   1      borrow-in; captured on the accepted start edge
//   busy    out  1      high while a subtraction is in progress
//   done    out  1      one-cycle pulse when D and Bout become valid
//   D       out  WIDTH  difference, (A - B - Bin) mod 2^WIDTH
//   Bout    out  1      borrow-out; 1 iff A < B + Bin (unsigned)
// BEHAVIOUR
//   - Interface: one clock (clk); synchronous active-high reset (rst).
//   - Reset: state <= IDLE; busy, done, Bout, D, shift regs, borrow, count all <= 0.
//   - The reset value of each output is 0.
//   - rst has priority over every other input on the same edge.
//   - Reset mid-RUN aborts the operation; no done pulse is issued.
//   - FSM states are IDLE, RUN and DONE.
//     IDLE: if start=1, load sa<=A, sb<=B, borrow<=Bin and count<=0, then go to RUN.
//           If start=0, stay in IDLE.
//     RUN: on each edge, compute the bit below from sa[0], sb[0] and borrow.
//           d    = sa[0] ^ sb[0] ^ borrow
//           bnxt = (~sa[0] & sb[0]) | (~sa[0] & borrow) | (sb[0] & borrow)
//         Then shift sa and sb right by 1, shift d into the result MSB (shift right),
//         set borrow<=bnxt and count<=count+1.
//         On the edge where count = WIDTH-1, the FSM does the following.
//           D <= the completed result; Bout <= bnxt; done <= 1; state <= DONE.
//     DONE: done is high for exactly this one cycle, and start is handled as in IDLE.
//           start=1 begins a new op and goes to RUN; done still drops next cycle.
//           start=0 goes to IDLE.
//   - busy = (state == RUN), registered.
//   - start is ignored while busy; A, B and Bin may change freely during RUN.
//   - Latency: accept start on edge 0; D, Bout and done update on edge WIDTH.
//     That gives WIDTH cycles per op and back-to-back ops every WIDTH+1 cycles.
//   - D and Bout hold their last values until the next completion or a reset.
//     They do not change while a new op is running.
//   - Width rule: count is clog2(WIDTH) bits wide; no intermediate exceeds WIDTH+1 bits.
//   - Wrap-around: an underflow wraps modulo 2^WIDTH and sets Bout=1, with no other flag.
// TESTING
//   All cases use WIDTH=4.
//   1. A=9, B=3, Bin=0, pulse start -> busy for 4 cycles; done at edge 4; D=6, Bout=0.
//   2. A=3, B=9, Bin=0 -> D=4'b1010 (10), Bout=1.
//   3. A=0, B=0, Bin=1 -> D=15, Bout=1.
//   4. A=15, B=15, Bin=0 -> D=0, Bout=0.
//      Then A=15, B=0, Bin=1 -> D=14, Bout=0.
//   5. Start A=9, B=3; at edge 2 assert start with A=1, B=1 -> the second start is ignored.
//      Expect done at edge 4 with D=6, and no second done pulse.
//   6. Assert rst at edge 2 of an op -> busy=0, done=0, D=0, Bout=0 on the next cycle.
//      No done pulse follows.
//   7. Sweep all A in 0..15, B in 0..15, Bin in 0..1 with start issued on each DONE cycle.
//      Check every result against {Bout, D} == {1'b0, A} - B - Bin (5-bit).

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// start/busy/done handshake; D and Bout hold until the next completion.
module serial_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             dbit;
    logic             bnxt;

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        dbit = sa[0] ^ sb[0] ^ borrow;
        bnxt = (~sa[0] & sb[0]) | (~sa[0] & borrow) | (sb[0] & borrow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Bout   <= 1'b0;
            D      <= '0;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa     <= A;
                        sb     <= B;
                        borrow <= Bin;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= {dbit, res[WIDTH-1:1]};
                    borrow <= bnxt;
                    count  <= count + 1'b1;
                    // Final bit: publish the result including this cycle's bit.
                    if (count == LAST) begin
                        D     <= {dbit, res[WIDTH-1:1]};
                        Bout  <= bnxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4): directed vectors, corner
// sequences and a full back-to-back sweep checked through a result queue.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       Bin = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] D;
    logic       Bout;

    int checks = 0;
    int passes = 0;
    logic [4:0] exp_q[$];

    serial_sub #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .D(D), .Bout(Bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {4'b0, bin};
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("scoreboard_result", {Bout, D}, e);
            end
        end
    end

    // Directed op with cycle-accurate handshake checks; called at a negedge.
    task automatic do_op(input vec_t v);
        A = v.a; B = v.b; Bin = v.bin; start = 1'b1;
        exp_q.push_back(model(v.a, v.b, v.bin));
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy_during_run", {busy, done}, 2'b10);
            if (k < 3) @(posedge clk);
        end
        @(posedge clk); @(negedge clk);
        check("done_edge4", {busy, done}, 2'b01);
        check("vec_result", {Bout, D}, {v.bout, v.d});
        @(negedge clk);
        check("done_one_cycle", {busy, done}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, d: 4'd6,  bout: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, d: 4'd10, bout: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'd15, bout: 1'b1};
        vecs[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, d: 4'd0,  bout: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, d: 4'd14, bout: 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", {busy, done, Bout, D}, 7'd0);

        for (int i = 0; i < 5; i++) do_op(vecs[i]);

        // Start while busy is ignored; operand changes mid-run have no effect.
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        exp_q.push_back(5'd6);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 begin start = 1'b1; A = 4'd1; B = 4'd1; end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("ignored_start_busy", busy, 1);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("ignored_start_done", {busy, done, Bout, D}, {2'b01, 5'd6});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_second_done", {busy, done}, 2'b00);
        end

        // Reset mid-run aborts without a done pulse and clears held outputs.
        A = 4'd3; B = 4'd9; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {busy, done, Bout, D}, 7'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_done", {busy, done}, 2'b00);
        end
        check("queue_empty_after_abort", exp_q.size(), 0);

        // Exhaustive sweep, each new start issued in the DONE cycle.
        for (int idx = 0; idx < 512; idx++) begin
            int cyc;
            A = idx[3:0]; B = idx[7:4]; Bin = idx[8]; start = 1'b1;
            exp_q.push_back(model(idx[3:0], idx[7:4], idx[8]));
            @(posedge clk); #1 start = 1'b0;
            cyc = 0;
            while (cyc < 12) begin
                @(negedge clk);
                cyc++;
                if (done) break;
            end
            if (!done) begin
                check("sweep_timeout", 0, 1);
                break;
            end
            check("sweep_latency", cyc, 5);
        end
        @(negedge clk);
        check("sweep_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
